// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Upstream feeder for the 5x5 matrix operation stages. Collects a byte stream
// over a valid/ready handshake into two packed matrices (matrizA first, then
// matrizB, both row-major), holds them stable and pulses load_done once both
// are complete.
//
// Packing: element (r,c) lives at bits [DATA_W*(DIM*r+c) +: DATA_W].
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle pulse: clear both matrices and begin a new load
//   size       (LOADER_SIZE_CFG_EN only) active size n, sampled on start
//   in_data    element value
//   in_valid   in_data is valid
//   in_ready   loader accepts in_data this cycle (combinational)
//   matrizA    first matrix, packed
//   matrizB    second matrix, packed
//   busy       load in progress (LOAD_A or LOAD_B), registered
//   load_done  one-cycle pulse: both matrices complete, registered
//
// Optional feature macro: LOADER_SIZE_CFG_EN
//   Defined   : adds size[2:0]; each matrix holds n*n elements with r,c < n,
//               where 0 or values above DIM clamp to DIM.
//   Undefined : fixed DIM x DIM load.
// -----------------------------------------------------------------------------
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef LOADER_SIZE_CFG_EN
  input  logic [2:0]                size,
`endif
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DIM*DIM*DATA_W-1:0] matrizA,
  output logic [DIM*DIM*DATA_W-1:0] matrizB,
  output logic                      busy,
  output logic                      load_done
);

  localparam int MW = DIM * DIM * DATA_W;
  localparam int NW = $clog2(DIM + 1);
  localparam int OW = $clog2(MW);
  localparam logic [NW-1:0] DIM_N = NW'(DIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_r;
  logic [NW-1:0]   row_r;
  logic [NW-1:0]   col_r;
  logic [MW-1:0]   mat_a_r;
  logic [MW-1:0]   mat_b_r;
  logic            busy_r;
  logic            load_done_r;
  logic [NW-1:0]   n_s;
  logic [NW-1:0]   n_m1_s;
  logic [OW-1:0]   off_s;

`ifdef LOADER_SIZE_CFG_EN
  logic [NW-1:0]   n_r;

  // Map a requested size onto 1..DIM; 0 and out-of-range requests mean full size.
  function automatic logic [NW-1:0] clamp_size(input logic [2:0] s);
    if ((s == 3'd0) || (int'(s) > DIM)) begin
      return DIM_N;
    end else begin
      return NW'(s);
    end
  endfunction

  assign n_s = n_r;
`else
  assign n_s = DIM_N;
`endif

  assign n_m1_s = n_s - NW'(1);

  // Bit offset of the element currently addressed by the row/column counters.
  assign off_s = OW'(row_r) * OW'(DIM * DATA_W) + OW'(col_r) * OW'(DATA_W);

  // start wins over a beat in the same cycle, so the ready is masked by it.
  assign in_ready  = ((state_r == LOAD_A) || (state_r == LOAD_B)) & ~start;
  assign matrizA   = mat_a_r;
  assign matrizB   = mat_b_r;
  assign busy      = busy_r;
  assign load_done = load_done_r;

  // Load FSM: counters, matrix storage and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      row_r       <= '0;
      col_r       <= '0;
      mat_a_r     <= '0;
      mat_b_r     <= '0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
`ifdef LOADER_SIZE_CFG_EN
      n_r         <= DIM_N;
`endif
    end else if (start) begin
      // Restart from any state; also drops a done pulse that would follow.
      state_r     <= LOAD_A;
      row_r       <= '0;
      col_r       <= '0;
      mat_a_r     <= '0;
      mat_b_r     <= '0;
      busy_r      <= 1'b1;
      load_done_r <= 1'b0;
`ifdef LOADER_SIZE_CFG_EN
      n_r         <= clamp_size(size);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          busy_r      <= 1'b0;
          load_done_r <= 1'b0;
        end
        LOAD_A, LOAD_B: begin
          load_done_r <= 1'b0;
          if (in_valid) begin
            if (state_r == LOAD_A) begin
              mat_a_r[off_s +: DATA_W] <= in_data;
            end else begin
              mat_b_r[off_s +: DATA_W] <= in_data;
            end
            if (col_r == n_m1_s) begin
              col_r <= '0;
              if (row_r == n_m1_s) begin
                // Last element of the active n x n window.
                row_r <= '0;
                if (state_r == LOAD_A) begin
                  state_r <= LOAD_B;
                end else begin
                  state_r     <= DONE;
                  busy_r      <= 1'b0;
                  load_done_r <= 1'b1;
                end
              end else begin
                row_r <= row_r + NW'(1);
              end
            end else begin
              col_r <= col_r + NW'(1);
            end
          end else begin
            col_r <= col_r;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          load_done_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          load_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
